// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision result packer.
package fpu_pkg;

   // FSM encoding, exposed on the debug state port of the packer.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NORM  = 3'd1,
      S_ROUND = 3'd2,
      S_PACK  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int               BIAS      = 127;
   localparam logic signed [9:0] EXP_MAX  = 10'sd255;
   localparam logic [31:0]      QNAN      = 32'h7fffffff;
   localparam logic [6:0]       RM_TRUNC  = 7'b0000000;
   localparam logic [6:0]       RM_TTE    = 7'b0000001;

   // A nonzero mantissa with [27:26] clear needs at most this many left shifts.
   localparam logic [4:0]       MAX_SHIFT = 5'd26;

endpackage

// File: rtl/fp_rounder.sv
// Combinational rounding of a normalized mantissa: round to nearest, ties to
// even, or truncation for every other mode. Guard/round/sticky are consumed
// and returned as zero.
module fp_rounder
   import fpu_pkg::*;
(
   input  logic [6:0]        rm,
   input  logic [26:0]       mant_in,   // [26] hidden, [25:3] fraction, [2:0] g/r/s
   input  logic signed [9:0] exp_in,
   output logic [27:0]       mant_out,
   output logic signed [9:0] exp_out
);

   logic        round_up;
   logic [24:0] sum;

   // Increment the significand when above half, or exactly half with an odd LSB;
   // a carry out renormalizes by one place to the right.
   always_comb begin
      round_up = (rm == RM_TTE) && mant_in[2] && (mant_in[1] || mant_in[0] || mant_in[3]);
      sum      = {1'b0, mant_in[26:3]} + {24'd0, round_up};
      mant_out = {1'b0, sum[23:0], 3'b000};
      exp_out  = exp_in;
      if (sum[24]) begin
         mant_out = {1'b0, sum[24:1], 3'b000};
         exp_out  = exp_in + 10'sd1;
      end
   end

endmodule

// File: rtl/packer.sv
// Normalizes, rounds and packs an unnormalized floating-point result into
// IEEE-754 single precision, one normalization step per clock.
//
// Handshake: a request (data_ready_i) is accepted only in IDLE or DONE; while
// busy_o is high requests are ignored. data_valid_o rises once the packed
// result is stable and stays high, with z_o and the flags held, until the next
// request is accepted.
module packer
   import fpu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_ready_i,
   input  logic [6:0]        rounding_mode_i,
   input  logic              sign_i,
   input  logic [9:0]        exp_i,
   input  logic [27:0]       mant_i,
   input  logic              nan_i,
   input  logic              infinity_i,
   output logic [31:0]       z_o,
   output logic              data_valid_o,
   output logic              busy_o,
   output logic              except_invalid_operation_o,
   output logic              except_overflow_o,
   output logic              except_underflow_o,
   output state_t            state_o
);

   state_t            state;
   state_t            state_n;
   logic              accept;

   logic              sign_q;
   logic signed [9:0] exp_q;
   logic [27:0]       mant_q;
   logic [6:0]        rm_q;
   logic              nan_q;
   logic              inf_q;
   logic [4:0]        shift_cnt;

   logic [27:0]       rnd_mant;
   logic signed [9:0] rnd_exp;

   logic [31:0]       pack_z;
   logic              pack_inv;
   logic              pack_ovf;
   logic              pack_unf;

   fp_rounder u_rounder (
      .rm       (rm_q),
      .mant_in  (mant_q[26:0]),
      .exp_in   (exp_q),
      .mant_out (rnd_mant),
      .exp_out  (rnd_exp)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state logic: NORM loops while shifting left, leaves early for
   // carry, zero, or an already-set hidden bit.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: if (data_ready_i) state_n = S_NORM;
         S_NORM: begin
            if (mant_q[27])                   state_n = S_ROUND;
            else if (mant_q == 28'd0)         state_n = S_PACK;
            else if (mant_q[26])              state_n = S_ROUND;
            else if (shift_cnt == MAX_SHIFT)  state_n = S_ROUND;
         end
         S_ROUND: state_n = S_PACK;
         S_PACK:  state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   // FSM-derived outputs and the request-accept strobe.
   always_comb begin
      busy_o  = (state == S_NORM) || (state == S_ROUND) || (state == S_PACK);
      accept  = data_ready_i && ((state == S_IDLE) || (state == S_DONE));
      state_o = state;
   end

   // Final encoding with NaN > infinity > zero > overflow > underflow priority.
   always_comb begin
      pack_z   = {sign_q, exp_q[7:0], mant_q[25:3]};
      pack_inv = 1'b0;
      pack_ovf = 1'b0;
      pack_unf = 1'b0;
      if (nan_q) begin
         pack_z   = QNAN;
         pack_inv = 1'b1;
      end else if (inf_q) begin
         pack_z   = {sign_q, 8'hff, 23'h0};
      end else if (mant_q == 28'd0) begin
         pack_z   = {sign_q, 31'h0};
      end else if (exp_q >= EXP_MAX) begin
         pack_z   = {sign_q, 8'hff, 23'h0};
         pack_ovf = 1'b1;
      end else if (exp_q <= 10'sd0) begin
         pack_z   = {sign_q, 31'h0};
         pack_unf = 1'b1;
      end
   end

   // Datapath: capture, normalize, round, pack, and the registered result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sign_q                     <= 1'b0;
         exp_q                      <= 10'sd0;
         mant_q                     <= 28'd0;
         rm_q                       <= 7'd0;
         nan_q                      <= 1'b0;
         inf_q                      <= 1'b0;
         shift_cnt                  <= 5'd0;
         z_o                        <= 32'd0;
         data_valid_o               <= 1'b0;
         except_invalid_operation_o <= 1'b0;
         except_overflow_o          <= 1'b0;
         except_underflow_o         <= 1'b0;
      end else if (accept) begin
         sign_q       <= sign_i;
         exp_q        <= exp_i;
         mant_q       <= mant_i;
         rm_q         <= rounding_mode_i;
         nan_q        <= nan_i;
         inf_q        <= infinity_i;
         shift_cnt    <= 5'd0;
         data_valid_o <= 1'b0;
      end else begin
         case (state)
            S_NORM: begin
               if (mant_q[27]) begin
                  // The bit shifted out is folded into sticky.
                  mant_q <= {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                  exp_q  <= exp_q + 10'sd1;
               end else if ((mant_q != 28'd0) && !mant_q[26] && (shift_cnt != MAX_SHIFT)) begin
                  mant_q    <= mant_q << 1;
                  exp_q     <= exp_q - 10'sd1;
                  shift_cnt <= shift_cnt + 5'd1;
               end
            end
            S_ROUND: begin
               mant_q <= rnd_mant;
               exp_q  <= rnd_exp;
            end
            S_PACK: begin
               z_o                        <= pack_z;
               except_invalid_operation_o <= pack_inv;
               except_overflow_o          <= pack_ovf;
               except_underflow_o         <= pack_unf;
            end
            S_DONE: data_valid_o <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 data_ready_i  input  1  start request; SHALL be sampled only in IDLE or DONE.
REQ-005 rounding_mode_i  input  7  rounding mode: 0 = truncate toward zero; 7'b0000001 = round to nearest, ties to even (TTE); any other value SHALL be treated as truncate.
REQ-006 sign_i  input  1  result sign.
REQ-007 exp_i  input  10  signed two's-complement biased exponent of the unnormalized result.
REQ-008 mant_i  input  28  mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 nan_i  input  1  result is NaN.
REQ-010 infinity_i  input  1  result is infinite.
REQ-011 z_o  output  32  packed IEEE-754 single-precision result.
REQ-012 data_valid_o  output  1  z_o and flags valid.
REQ-013 busy_o  output  1  high in NORM, ROUND and PACK.
REQ-014 except_invalid_operation_o  output  1  NaN result.
REQ-015 except_overflow_o  output  1  overflow to infinity.
REQ-016 except_underflow_o  output  1  flush to zero.

Function
REQ-017 The FSM SHALL have states IDLE, NORM, ROUND, PACK and DONE.
REQ-018 In IDLE or DONE with data_ready_i=1, the block SHALL capture all inputs, clear data_valid_o and enter NORM.
REQ-019 In NORM with mant[27]=1, the block SHALL shift right 1 (OR the lost bit into sticky), increment exp and go to ROUND.
REQ-020 In NORM with mant=0, the block SHALL go to PACK and produce a signed zero.
REQ-021 In NORM with mant[26]=1, the block SHALL go to ROUND.
REQ-022 Otherwise in NORM, the block SHALL shift left 1 and decrement exp, one bit per cycle, for at most 26 cycles.
REQ-023 In ROUND under TTE, the block SHALL increment [26:3] when guard=1 and (round|sticky|mant[3])=1; a resulting carry into [27] SHALL shift right 1 and increment exp. Under truncate, it SHALL discard [2:0].
REQ-024 In PACK, priority SHALL be:
- nan_i: z=32'h7fffffff, invalid=1.
- infinity_i: z={sign,8'hff,23'h0}.
- exp>=255: z={sign,8'hff,23'h0}, overflow=1.
- exp<=0 with nonzero mant: z={sign,31'h0}, underflow=1 (no subnormals).
- else: z={sign,exp[7:0],mant[25:3]}.
REQ-025 PACK SHALL always go to DONE; in DONE, data_valid_o=1 and z_o and the flags SHALL hold until the next accepted data_ready_i.
REQ-026 Latency: with k left shifts, data_valid_o SHALL rise 4+k cycles after the capture edge (4 for normalized input).
REQ-027 data_ready_i SHALL be ignored while busy_o=1.
REQ-028 The exponent SHALL be held at 10 bits signed internally so that over- and underflow are detected without wrap.

Reset
REQ-029 rst_i SHALL force IDLE with z_o=0, data_valid_o=0, busy_o=0, all flags 0 and internal registers 0.
REQ-030 rst_i asserted mid-operation SHALL abort the operation; no data_valid_o SHALL follow for the aborted operation.

Structure
REQ-031 Package fpu_pkg SHALL hold the state enum, BIAS=127, EXP_MAX=255, QNAN=32'h7fffffff, and the RM_TRUNC/RM_TTE constants.
REQ-032 Rounding logic SHALL be one combinational sub-module, fp_rounder.

Verification
REQ-033 sign=0, exp=127, mant=28'h4000000, truncate -> z=32'h3f800000, data_valid_o at cycle 4.
REQ-034 exp=126, mant=28'h0800000 -> 3 shifts, z=32'h3d800000, data_valid_o at cycle 7.
REQ-035 exp=136, mant=28'h7fffffc: truncate -> 32'h447fffff; TTE -> 32'h44800000.
REQ-036 exp=254, mant=28'h8000000 -> z=32'h7f800000, overflow=1; exp=1, mant=28'h0000008 -> z=0, underflow=1.
REQ-037 nan_i=1 -> 32'h7fffffff, invalid=1; infinity_i=1 with sign=1 -> 32'hff800000, no flags.
REQ-038 rst_i in NORM -> IDLE with outputs 0; data_ready_i pulsed while busy -> ignored; the following operation SHALL be correct.
